task_join_ctrl: RTL

Synthesisable fork/join controller for the verification-infrastructure and sequencing layer. On `start` it launches up to N_CH child engines with a one-cycle `launch` pulse and collects their `done_in` pulses. It releases the parent with `join_done` according to a per-episode mode: join-all, join-any or join-none. Whatever the mode, it keeps tracking the remaining children until `all_done` or a cycle timeout.

---
 rtl/task_join_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/task_join_ctrl.sv
// Fork/join controller: launches up to N_CH children and releases the parent in join-all,
// join-any or join-none mode. Optional episode timeout enabled by TASK_JOIN_TIMEOUT_EN.
module task_join_ctrl #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned TIMEOUT_W = 16,
    parameter int unsigned ID_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [N_CH-1:0]      en_mask,
    input  logic [TIMEOUT_W-1:0] timeout,
    input  logic [N_CH-1:0]      done_in,
    output logic [N_CH-1:0]      launch,
    output logic                 busy,
    output logic                 join_done,
    output logic                 all_done,
    output logic [N_CH-1:0]      done_vec,
    output logic [ID_W-1:0]      first_id,
    output logic                 timed_out,
    output logic [TIMEOUT_W-1:0] elapsed
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StLaunch = 2'd1;
    localparam logic [1:0] StWait   = 2'd2;
    localparam logic [1:0] StDrain  = 2'd3;

    localparam logic [1:0] ModeAny  = 2'd1;
    localparam logic [1:0] ModeNone = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [1:0]           mode_q;
    logic [N_CH-1:0]      mask_q, launch_q, done_vec_q;
    logic [N_CH-1:0]      acc, vec_next;
    logic                 join_given_q, join_done_q, all_done_q;
    logic [ID_W-1:0]      first_id_q, low_idx;
    logic [TIMEOUT_W-1:0] elapsed_q;
    logic                 active, fill, to_fire, join_d, all_d, given_d;

`ifdef TASK_JOIN_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] timeout_q;
    logic                 timed_out_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout;
`endif

    always_comb begin
        // The all_done cycle closes the episode; nothing more is accepted there.
        active   = (state_q != StIdle) && !all_done_q;
        acc      = active ? (done_in & mask_q & ~done_vec_q) : '0;
        vec_next = done_vec_q | acc;
        fill     = (acc != '0) && (vec_next == mask_q);
        low_idx  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (acc[i]) low_idx = ID_W'(i);
        end
`ifdef TASK_JOIN_TIMEOUT_EN
        to_fire = active && (state_q == StWait || state_q == StDrain) &&
                  (timeout_q != '0) && (elapsed_q == timeout_q) && !fill;
`else
        to_fire = 1'b0;
`endif
        join_d  = !join_given_q && (fill || to_fire || (mode_q == ModeAny && acc != '0));
        all_d   = fill || to_fire;
        given_d = join_given_q || join_d;
        state_d = given_d ? StDrain : StWait;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            mode_q       <= '0;
            mask_q       <= '0;
            launch_q     <= '0;
            done_vec_q   <= '0;
            join_given_q <= 1'b0;
            join_done_q  <= 1'b0;
            all_done_q   <= 1'b0;
            first_id_q   <= '0;
            elapsed_q    <= '0;
`ifdef TASK_JOIN_TIMEOUT_EN
            timeout_q    <= '0;
            timed_out_q  <= 1'b0;
`endif
        end else begin
            launch_q    <= '0;
            join_done_q <= 1'b0;
            all_done_q  <= 1'b0;
            if (state_q == StIdle) begin
                if (start) begin
                    state_q      <= StLaunch;
                    mode_q       <= mode;
                    mask_q       <= en_mask;
                    launch_q     <= en_mask;
                    join_done_q  <= (mode == ModeNone) || (en_mask == '0);
                    join_given_q <= (mode == ModeNone) || (en_mask == '0);
                    all_done_q   <= (en_mask == '0);
                    done_vec_q   <= '0;
                    first_id_q   <= '0;
                    elapsed_q    <= '0;
`ifdef TASK_JOIN_TIMEOUT_EN
                    timeout_q    <= timeout;
                    timed_out_q  <= 1'b0;
`endif
                end
            end else if (all_done_q) begin
                state_q <= StIdle;
            end else begin
                state_q      <= state_d;
                done_vec_q   <= vec_next;
                join_done_q  <= join_d;
                all_done_q   <= all_d;
                join_given_q <= given_d;
                if (done_vec_q == '0 && acc != '0) first_id_q <= low_idx;
                if (elapsed_q != '1) elapsed_q <= elapsed_q + TIMEOUT_W'(1);
`ifdef TASK_JOIN_TIMEOUT_EN
                if (to_fire) timed_out_q <= 1'b1;
`endif
            end
        end
    end

    assign launch    = launch_q;
    assign busy      = (state_q != StIdle);
    assign join_done = join_done_q;
    assign all_done  = all_done_q;
    assign done_vec  = done_vec_q;
    assign first_id  = first_id_q;
    assign elapsed   = elapsed_q;
`ifdef TASK_JOIN_TIMEOUT_EN
    assign timed_out = timed_out_q;
`else
    assign timed_out = 1'b0;
`endif

endmodule
